// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one valid/ready RAM port among NUM_REQ requesters.
// One command in flight at a time; write acks and read data return to the granted requester.
module dpram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]           resp_rdata,
  output logic                        ram_valid,
  input  logic                        ram_ready,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_data,
  input  logic [DATA_W-1:0]           ram_q,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [ID_W-1:0]     winner;
  logic                found;

  // Scan from the requester after the last grant, wrapping; first valid wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          ram_we_d     = req_we[winner];
          ram_addr_d   = req_addr[int'(winner)*ADDR_W +: ADDR_W];
          ram_data_d   = req_wdata[int'(winner)*DATA_W +: DATA_W];
          grant_id_d   = winner;
          last_grant_d = winner;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (ram_ready) begin
          if (ram_we_q) begin
            resp_valid_d[grant_id_q] = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        // ram_q is valid this cycle, one cycle after the read handshake.
        resp_rdata_d             = ram_q;
        resp_valid_d[grant_id_q] = 1'b1;
        state_d                  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign ram_valid  = (state_q == ISSUE);
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign grant_id   = grant_id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: directed literal checks plus randomized traffic
// against a transaction-level reference model with a shadow memory.
module tb_dpram_port_arbiter;
  localparam int N = 4, AW = 8, DW = 8, IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   resp_rdata, ram_data, ram_q;
  logic            ram_valid, ram_ready, ram_we, busy;
  logic [AW-1:0]   ram_addr;
  logic [IW-1:0]   grant_id;

  int n_vec = 0, n_err = 0;

  dpram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_q(ram_q), .grant_id(grant_id), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM environment: write on handshake, read data registered one cycle later.
  logic [DW-1:0] mem [256];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i ^ 'h5A);
      mem_init <= 1'b1;
    end else if (ram_valid && ram_ready) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      else        ram_q <= mem[ram_addr];
    end
  end

  // Reference model: port ownership, shadow memory, expected responses.
  logic [DW-1:0] smem [256];
  logic          m_on = 1'b0;
  int            m_phase, m_last, m_id;   // phase: 0 port free, 1 command on RAM, 2 read data returning
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_pend, m_rdata;
  logic [N-1:0]  m_resp;

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    logic [N-1:0] nresp;
    w = pick(req_valid, m_last);
    if (m_on) begin
      chk("req_ready", 32'(req_ready), (m_phase == 0 && w >= 0) ? 32'(1 << w) : 32'd0);
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("ram_valid", 32'(ram_valid), 32'(m_phase == 1));
      if (m_phase == 1) begin
        chk("ram_we", 32'(ram_we), 32'(m_we));
        chk("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk("ram_data", 32'(ram_data), 32'(m_data));
      end
      chk("grant_id", 32'(grant_id), 32'(m_id));
      chk("resp_valid", 32'(resp_valid), 32'(m_resp));
      chk("resp_rdata", 32'(resp_rdata), 32'(m_rdata));
    end
    // The RAM side completes a write even if the arbiter is reset on that edge.
    if (m_on && m_phase == 1 && ram_ready && m_we) smem[m_addr] = m_data;
    if (rst) begin
      m_on = 1'b1; m_phase = 0; m_last = N - 1; m_id = 0; m_resp = '0; m_rdata = '0;
    end else if (m_on) begin
      nresp = '0;
      if (m_phase == 0) begin
        if (w >= 0) begin
          m_id = w; m_last = w; m_we = req_we[w];
          m_addr = req_addr[w*AW +: AW]; m_data = req_wdata[w*DW +: DW];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (ram_ready) begin
          if (m_we) begin nresp[m_id] = 1'b1; m_phase = 0; end
          else begin m_pend = smem[m_addr]; m_phase = 2; end
        end
      end else begin
        m_rdata = m_pend; nresp[m_id] = 1'b1; m_phase = 0;
      end
      m_resp = nresp;
    end
  end

  // Grant log for order checks.
  int gq[$];
  always @(negedge clk)
    if (!rst) for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) gq.push_back(i);

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic neg(); @(negedge clk); endtask
  task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i] = we; req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
  endtask
  task automatic wait_grants(input int n, input string nm);
    for (int c = 0; c < 60 && gq.size() < n; c++) neg();
    if (gq.size() < n) chk(nm, 32'(gq.size()), 32'(n));
  endtask
  task automatic do_reset(); rst = 1'b1; tick(); rst = 1'b0; gq.delete(); endtask

  initial begin
    int exp_ord[5];
    logic [N-1:0] hs;
    for (int i = 0; i < 256; i++) smem[i] = 8'(i ^ 'h5A);
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; ram_ready = 1'b1;
    repeat (3) tick();
    neg();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ram_valid", 32'(ram_valid), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_rdata", 32'(resp_rdata), 0);
    tick(); rst = 1'b0; gq.delete();

    // Requester 2 write 0x10 <= 0xA5, then read it back.
    set_cmd(2, 1'b1, 8'h10, 8'hA5); req_valid = 4'b0100;
    neg(); chk("wr_ready", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    neg(); chk("wr_T1_valid", 32'(ram_valid), 1); chk("wr_T1_we", 32'(ram_we), 1);
    chk("wr_T1_addr", 32'(ram_addr), 32'h10); chk("wr_T1_data", 32'(ram_data), 32'hA5);
    tick(); neg(); chk("wr_T2_resp", 32'(resp_valid), 32'h4);
    tick(); set_cmd(2, 1'b0, 8'h10, 8'h00); req_valid = 4'b0100;
    neg(); tick(); req_valid = '0;
    neg(); tick(); neg(); chk("rd_T2_resp", 32'(resp_valid), 0);
    tick(); neg(); chk("rd_T3_resp", 32'(resp_valid), 32'h4); chk("rd_T3_rdata", 32'(resp_rdata), 32'hA5);
    tick();

    // All four hold reads from reset: order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 8'(8'h20 + i), 8'h00);
    req_valid = 4'hF;
    wait_grants(5, "rot_timeout");
    tick(); req_valid = '0;
    exp_ord = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) if (k < gq.size()) chk("rot_order", 32'(gq[k]), 32'(exp_ord[k]));
    repeat (4) tick();

    // last_grant=1; 1 and 3 request, 0 joins before second grant: order 3,0,1.
    do_reset();
    set_cmd(1, 1'b1, 8'h30, 8'h11); req_valid = 4'b0010;
    neg(); tick(); req_valid = '0;
    repeat (3) tick(); gq.delete();
    set_cmd(1, 1'b0, 8'h30, 8'h00); set_cmd(3, 1'b0, 8'h33, 8'h00); set_cmd(0, 1'b0, 8'h31, 8'h00);
    req_valid = 4'b1010;
    wait_grants(1, "rr_timeout1"); tick(); req_valid = 4'b0011;
    wait_grants(2, "rr_timeout2"); tick(); req_valid = 4'b0010;
    wait_grants(3, "rr_timeout3"); tick(); req_valid = '0;
    exp_ord = '{3, 0, 1, 0, 0};
    for (int k = 0; k < 3; k++) if (k < gq.size()) chk("rr_order", 32'(gq[k]), 32'(exp_ord[k]));
    repeat (4) tick();

    // Backpressure: 5 stalled cycles in ISSUE.
    set_cmd(0, 1'b1, 8'h40, 8'h77); req_valid = 4'b0001; ram_ready = 1'b0;
    neg(); chk("bp_ready", 32'(req_ready), 32'h1);
    tick(); set_cmd(1, 1'b0, 8'h41, 8'h00); req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      neg();
      chk("bp_valid", 32'(ram_valid), 1); chk("bp_addr", 32'(ram_addr), 32'h40);
      chk("bp_data", 32'(ram_data), 32'h77); chk("bp_rdy", 32'(req_ready), 0); chk("bp_busy", 32'(busy), 1);
      tick();
    end
    ram_ready = 1'b1;
    neg(); chk("bp_hs_valid", 32'(ram_valid), 1);
    tick(); neg(); chk("bp_resp", 32'(resp_valid), 32'h1);
    tick(); req_valid = '0;
    repeat (4) tick();

    // Reset while a read is pending in ISSUE.
    set_cmd(3, 1'b0, 8'h22, 8'h00); req_valid = 4'b1000; ram_ready = 1'b0;
    neg(); tick(); req_valid = '0; rst = 1'b1;
    neg(); chk("rsti_valid_before", 32'(ram_valid), 1);
    tick(); rst = 1'b0;
    neg(); chk("rsti_valid", 32'(ram_valid), 0); chk("rsti_busy", 32'(busy), 0); chk("rsti_resp", 32'(resp_valid), 0);
    tick(); neg(); chk("rsti_resp2", 32'(resp_valid), 0);
    tick(); ram_ready = 1'b1;
    for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 8'(8'h50 + i), 8'h00);
    req_valid = 4'hF;
    neg(); chk("rsti_winner", 32'(req_ready), 32'h1);
    tick(); req_valid = '0;
    repeat (4) tick();

    // Idle gap does not rotate priority.
    set_cmd(1, 1'b1, 8'h60, 8'h3C); req_valid = 4'b0010;
    neg(); tick(); req_valid = '0;
    repeat (12) tick();
    set_cmd(0, 1'b0, 8'h61, 8'h00); set_cmd(2, 1'b0, 8'h62, 8'h00); req_valid = 4'b0101;
    neg(); chk("gap_winner", 32'(req_ready), 32'h4);
    tick(); req_valid = '0;
    repeat (4) tick();

    // Randomized traffic, random backpressure and rare resets.
    for (int c = 0; c < 3000; c++) begin
      neg(); hs = req_valid & req_ready;
      tick();
      rst = ($urandom_range(0, 399) == 0);
      ram_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (hs[i] || !req_valid[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          set_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end
    end
    rst = 1'b0; req_valid = '0; ram_ready = 1'b1;
    repeat (8) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end
endmodule
